// File: rtl/decoder_pkg.sv
// decoder_pkg: shared width derivation and one-hot helper for decoders/encoders
package decoder_pkg;
  localparam int MAX_IN  = 8;
  localparam int MAX_OUT = 1 << MAX_IN;
  function automatic int out_width(input int iw);
    return 1 << iw;
  endfunction
  function automatic logic [MAX_OUT-1:0] onehot(input logic [MAX_IN-1:0] idx);
    return MAX_OUT'(1) << idx;
  endfunction
endpackage

// File: rtl/decoder_core.sv
// decoder_core: purely combinational binary-to-one-hot conversion
module decoder_core
  import decoder_pkg::*;
#(
  parameter int INPUT_WIDTH = 5,
  localparam int OUTPUT_WIDTH = out_width(INPUT_WIDTH)
) (
  input  logic [INPUT_WIDTH-1:0]  in,
  output logic [OUTPUT_WIDTH-1:0] out
);
  // X on in propagates through the shift; no sanitising on purpose
  assign out = OUTPUT_WIDTH'(onehot(MAX_IN'(in)));
endmodule

// File: rtl/decoder.sv
// decoder: one-hot decoder with enable-gated copy and registered, valid-flagged copy
module decoder
  import decoder_pkg::*;
#(
  parameter int INPUT_WIDTH = 5,
  localparam int OUTPUT_WIDTH = out_width(INPUT_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [INPUT_WIDTH-1:0]  in,
  input  logic                    en,
  output logic [OUTPUT_WIDTH-1:0] out,
  output logic [OUTPUT_WIDTH-1:0] out_gated,
  output logic [OUTPUT_WIDTH-1:0] out_q,
  output logic                    valid_q
);
  decoder_core #(.INPUT_WIDTH(INPUT_WIDTH)) u_core (.in(in), .out(out));
  assign out_gated = en ? out : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else if (en) begin
      out_q   <= out;
      valid_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_decoder.sv
// tb_decoder: directed self-checking bench for decoder at widths 5, 1 and 8
module tb_decoder;
  logic clk = 1'b0;
  logic rst_n, en;
  logic [4:0] in;
  logic [31:0] out, out_gated, out_q;
  logic valid_q;
  logic free_clk, free_rst_n, free_en;
  logic [4:0] free_in;
  logic [31:0] free_out, free_gated, free_q;
  logic free_valid;
  logic in1;
  logic [1:0] out1, gated1, q1;
  logic valid1;
  logic [7:0] in8;
  logic [255:0] out8, gated8, q8;
  logic valid8;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  decoder #(.INPUT_WIDTH(5)) dut (.clk(clk), .rst_n(rst_n), .in(in), .en(en),
    .out(out), .out_gated(out_gated), .out_q(out_q), .valid_q(valid_q));
  decoder #(.INPUT_WIDTH(5)) u_free (.clk(free_clk), .rst_n(free_rst_n), .in(free_in), .en(free_en),
    .out(free_out), .out_gated(free_gated), .out_q(free_q), .valid_q(free_valid));
  decoder #(.INPUT_WIDTH(1)) u_w1 (.clk(clk), .rst_n(rst_n), .in(in1), .en(en),
    .out(out1), .out_gated(gated1), .out_q(q1), .valid_q(valid1));
  decoder #(.INPUT_WIDTH(8)) u_w8 (.clk(clk), .rst_n(rst_n), .in(in8), .en(en),
    .out(out8), .out_gated(gated8), .out_q(q8), .valid_q(valid8));

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (valid_q === 1'b1) chk("onehot_q", 256'($onehot(out_q)), 256'(1));
    else if (valid_q === 1'b0) chk("zero_q", 256'(out_q), 256'(0));
  end

  initial begin
    logic [4:0] seq [4] = '{5'd0, 5'd1, 5'd2, 5'd31};
    rst_n = 1'b0; en = 1'b0; in = '0; in1 = 1'b0; in8 = '0;
    for (int i = 0; i < 32; i++) begin
      free_in = 5'(i);
      #1 chk($sformatf("sweep%0d", i), 256'(free_out), 256'(32'h1 << i));
    end
    free_in = 5'b10011;
    #1 chk("sweep19", 256'(free_out), 256'(32'h0008_0000));
    in = 5'd3; en = 1'b0;
    #1 chk("gate_off", 256'(out_gated), 256'(0));
    chk("gate_out", 256'(out), 256'(32'h8));
    en = 1'b1;
    #1 chk("gate_on", 256'(out_gated), 256'(32'h8));
    rst_n = 1'b0; in = 5'd7;
    tick(); tick();
    chk("rst_q", 256'(out_q), 256'(0));
    chk("rst_v", 256'(valid_q), 256'(0));
    rst_n = 1'b1;
    tick();
    chk("rel_q", 256'(out_q), 256'(32'h80));
    chk("rel_v", 256'(valid_q), 256'(1));
    in = 5'd4;
    tick();
    chk("cap4", 256'(out_q), 256'(32'h10));
    en = 1'b0; in = 5'd9;
    repeat (3) tick();
    chk("hold_q", 256'(out_q), 256'(32'h10));
    chk("hold_out", 256'(out), 256'(32'h200));
    chk("hold_v", 256'(valid_q), 256'(1));
    en = 1'b1;
    foreach (seq[k]) begin
      in = seq[k];
      tick();
      chk($sformatf("b2b%0d", k), 256'(out_q), 256'(32'h1 << seq[k]));
    end
    in = 5'd6; rst_n = 1'b0;
    tick();
    chk("mid_rst_q", 256'(out_q), 256'(0));
    chk("mid_rst_v", 256'(valid_q), 256'(0));
    chk("mid_rst_out", 256'(out), 256'(32'h40));
    chk("mid_rst_gated", 256'(out_gated), 256'(32'h40));
    rst_n = 1'b1;
    in1 = 1'b1; in8 = 8'd255;
    #1 chk("w1_out", 256'(out1), 256'(2'b10));
    chk("w8_out", out8, 256'(1) << 255);
    in1 = 1'b0; in8 = 8'd0;
    #1 chk("w1_out0", 256'(out1), 256'(2'b01));
    chk("w8_out0", out8, 256'(1));
    in8 = 8'd200;
    tick();
    chk("w8_q", q8, 256'(1) << 200);
    chk("w1_q", 256'(q1), 256'(2'b01));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
